// File: rtl/program_loader.sv
// Program loader: accepts decoded ISA fields during a load session, packs them
// into 16-bit instruction words, buffers them in a 4-entry FIFO and streams them
// to program memory at consecutive addresses with a valid/ready style handshake.
// Illegal opcodes are consumed and flagged without being written.
module program_loader (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic        load_end,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  in_opcode,
    input  logic [3:0]  in_dst,
    input  logic [3:0]  in_op2,
    input  logic [3:0]  in_op3,
    output logic        mem_we,
    input  logic        mem_ready,
    output logic [7:0]  mem_addr,
    output logic [15:0] mem_wdata,
    output logic [8:0]  count,
    output logic        busy,
    output logic        done,
    output logic        err_illegal,
    output logic        err_full
);

    localparam int unsigned Depth     = 4;
    localparam logic [3:0]  IllegalOp = 4'b1100;
    localparam logic [9:0]  MaxCount  = 10'd256;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StFlush,
        StDone
    } state_e;

    state_e state;

    // FIFO storage and bookkeeping
    logic [15:0] fifo_mem [Depth];
    logic [1:0]  wr_ptr;
    logic [1:0]  rd_ptr;
    logic [2:0]  occ;

    logic        fifo_full;
    logic        fifo_empty;
    logic [9:0]  pending;
    logic        room;
    logic        at_cap;
    logic        is_load;
    logic        is_flush;
    logic        is_illegal;
    logic        transfer;
    logic        push;
    logic        pop;
    logic [15:0] in_word;

    // Handshake and datapath decode, all derived from registered state
    always_comb begin
        is_load    = (state == StLoad);
        is_flush   = (state == StFlush);
        fifo_full  = (occ == 3'd4);
        fifo_empty = (occ == 3'd0);
        // Words already written plus words still buffered; must never exceed 256
        pending    = {1'b0, count} + {7'b0, occ};
        room       = (pending < MaxCount);
        at_cap     = (pending == MaxCount);
        in_word    = {in_opcode, in_dst, in_op2, in_op3};
        is_illegal = (in_opcode == IllegalOp);

        in_ready   = is_load && !fifo_full && room;
        transfer   = in_valid && in_ready;
        push       = transfer && !is_illegal;

        // FIFO registers are cleared by rst, so mem_we drops with reset immediately
        mem_we     = (is_load || is_flush) && !fifo_empty;
        pop        = mem_we && mem_ready;
        mem_wdata  = mem_we ? fifo_mem[rd_ptr] : 16'h0000;
    end

    // FIFO storage: data needs no reset, validity is tracked by occ
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= in_word;
        end
    end

    // FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            occ    <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 2'd1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 2'd1;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 3'd1;
                2'b01:   occ <= occ - 3'd1;
                default: occ <= occ;
            endcase
        end
    end

    // Session FSM with registered status, address, count and sticky error flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            busy        <= 1'b0;
            done        <= 1'b0;
            count       <= 9'd0;
            mem_addr    <= 8'd0;
            err_illegal <= 1'b0;
            err_full    <= 1'b0;
        end else begin
            // Completed write; the address saturates so it never wraps to 0
            if (pop) begin
                count <= count + 9'd1;
                if (mem_addr != 8'hFF) begin
                    mem_addr <= mem_addr + 8'd1;
                end
            end

            unique case (state)
                StIdle, StDone: begin
                    if (load_start) begin
                        state       <= StLoad;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        count       <= 9'd0;
                        mem_addr    <= 8'd0;
                        err_illegal <= 1'b0;
                        err_full    <= 1'b0;
                    end
                end
                StLoad: begin
                    if (transfer && is_illegal) begin
                        err_illegal <= 1'b1;
                    end
                    if (in_valid && at_cap) begin
                        err_full <= 1'b1;
                    end
                    if (load_end) begin
                        state <= StFlush;
                    end
                end
                StFlush: begin
                    if (fifo_empty) begin
                        state <= StDone;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: table-driven instruction vectors plus hand-written
// sessions for backpressure, capacity, coincident events and reset mid-flush.
// Expected memory writes go into a queue when an instruction is accepted and are
// compared when the DUT performs the write.
module tb_program_loader;

    logic        clk;
    logic        rst;
    logic        load_start;
    logic        load_end;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_opcode;
    logic [3:0]  in_dst;
    logic [3:0]  in_op2;
    logic [3:0]  in_op3;
    logic        mem_we;
    logic        mem_ready;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic [8:0]  count;
    logic        busy;
    logic        done;
    logic        err_illegal;
    logic        err_full;

    program_loader dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .load_end   (load_end),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_dst     (in_dst),
        .in_op2     (in_op2),
        .in_op3     (in_op3),
        .mem_we     (mem_we),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .count      (count),
        .busy       (busy),
        .done       (done),
        .err_illegal(err_illegal),
        .err_full   (err_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    typedef struct {
        logic [15:0] word;
        logic        exp_ill;
    } vec_t;

    wr_t        exp_q[$];
    vec_t       vecs[8];
    int         nvec;
    int         nbad;
    logic [7:0] next_addr;
    logic       accepted;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Observe the cycle at negedge, then advance to just after the next posedge
    task automatic tick();
        wr_t e;
        @(negedge clk);
        accepted = in_valid && in_ready;
        if (accepted && in_opcode != 4'hC) begin
            exp_q.push_back({next_addr, in_opcode, in_dst, in_op2, in_op3});
            next_addr = next_addr + 8'd1;
        end
        if (mem_we && mem_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(e.addr));
                check("wr_data", 32'(mem_wdata), 32'(e.data));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_word(input logic [15:0] w);
        {in_opcode, in_dst, in_op2, in_op3} = w;
    endtask

    task automatic offer(input logic [15:0] w, input int budget);
        logic got;
        got = 1'b0;
        set_word(w);
        in_valid = 1'b1;
        for (int i = 0; i < budget && !got; i++) begin
            tick();
            got = accepted;
        end
        in_valid = 1'b0;
        if (!got) check("offer_timeout", 32'(got), 32'd1);
    endtask

    task automatic start_session();
        next_addr  = 8'd0;
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic end_session();
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !done; i++) tick();
        check("done_reached", 32'(done), 32'd1);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic any_acc;
        nvec       = 0;
        nbad       = 0;
        next_addr  = 8'd0;
        accepted   = 1'b0;
        rst        = 1'b1;
        load_start = 1'b0;
        load_end   = 1'b0;
        in_valid   = 1'b0;
        mem_ready  = 1'b0;
        set_word(16'h0000);

        vecs[0] = '{16'h1200, 1'b0};
        vecs[1] = '{16'hC123, 1'b1};
        vecs[2] = '{16'h4321, 1'b1};
        vecs[3] = '{16'h03A5, 1'b1};
        vecs[4] = '{16'hCFFF, 1'b1};
        vecs[5] = '{16'hFFFF, 1'b1};
        vecs[6] = '{16'h0000, 1'b1};
        vecs[7] = '{16'hB7E1, 1'b1};

        // Reset state
        repeat (3) tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'({err_illegal, err_full}), 32'd0);
        rst = 1'b0;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd0);

        // Basic load
        mem_ready = 1'b1;
        start_session();
        check("basic_busy", 32'(busy), 32'd1);
        check("basic_count0", 32'(count), 32'd0);
        offer(16'h03A5, 4);
        offer(16'hD002, 4);
        end_session();
        wait_done(20);
        check("basic_count", 32'(count), 32'd2);
        check("basic_busy_done", 32'(busy), 32'd0);

        // Table-driven vectors including illegal opcodes
        start_session();
        foreach (vecs[i]) begin
            offer(vecs[i].word, 4);
            check("vec_err_illegal", 32'(err_illegal), 32'(vecs[i].exp_ill));
        end
        end_session();
        wait_done(20);
        check("vec_count", 32'(count), 32'd6);
        check("vec_err_held", 32'(err_illegal), 32'd1);

        // Backpressure: four fill the FIFO, the fifth waits
        mem_ready = 1'b0;
        start_session();
        offer(16'h1111, 3);
        offer(16'h2222, 3);
        offer(16'h3333, 3);
        offer(16'h4444, 3);
        set_word(16'h5555);
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("bp_accepted", 32'(accepted), 32'd0);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_mem_we", 32'(mem_we), 32'd1);
            check("bp_addr", 32'(mem_addr), 32'd0);
            check("bp_data", 32'(mem_wdata), 32'h1111);
        end
        mem_ready = 1'b1;
        any_acc = 1'b0;
        for (int i = 0; i < 6 && !any_acc; i++) begin
            tick();
            any_acc = accepted;
        end
        in_valid = 1'b0;
        check("bp_fifth_accepted", 32'(any_acc), 32'd1);
        end_session();
        wait_done(20);
        check("bp_count", 32'(count), 32'd5);

        // Capacity: 257 offered, 256 written
        start_session();
        for (int i = 0; i < 256; i++) offer({4'h2, 4'h0, 8'(i)}, 4);
        set_word(16'h2FFF);
        in_valid = 1'b1;
        any_acc = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            any_acc = any_acc | accepted;
        end
        check("cap_257_rejected", 32'(any_acc), 32'd0);
        check("cap_in_ready", 32'(in_ready), 32'd0);
        check("cap_err_full", 32'(err_full), 32'd1);
        in_valid = 1'b0;
        end_session();
        wait_done(20);
        check("cap_count", 32'(count), 32'd256);
        check("cap_err_full_held", 32'(err_full), 32'd1);

        // load_end coincident with a transfer, then restart from DONE
        start_session();
        offer(16'hC000, 4);
        set_word(16'h7ABC);
        in_valid = 1'b1;
        load_end = 1'b1;
        tick();
        check("end_xfer_accepted", 32'(accepted), 32'd1);
        in_valid = 1'b0;
        load_end = 1'b0;
        wait_done(20);
        check("end_xfer_count", 32'(count), 32'd1);
        check("end_xfer_err", 32'(err_illegal), 32'd1);
        load_end = 1'b1;
        tick();
        load_end = 1'b0;
        check("done_ignores_end", 32'(done), 32'd1);
        check("done_holds_count", 32'(count), 32'd1);
        start_session();
        check("restart_count", 32'(count), 32'd0);
        check("restart_flags", 32'({err_illegal, err_full}), 32'd0);
        check("restart_addr", 32'(mem_addr), 32'd0);
        check("restart_status", 32'({busy, done}), 32'b10);
        offer(16'h1357, 4);
        tick();
        tick();
        check("restart_written", 32'(count), 32'd1);
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        check("load_ignores_start", 32'(count), 32'd1);
        check("load_ignores_start_busy", 32'(busy), 32'd1);
        end_session();
        wait_done(20);

        // Reset during FLUSH with three entries pending
        mem_ready = 1'b0;
        start_session();
        offer(16'h0A01, 3);
        offer(16'h0A02, 3);
        offer(16'h0A03, 3);
        end_session();
        check("flush_mem_we", 32'(mem_we), 32'd1);
        check("flush_busy", 32'(busy), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_mem_we", 32'(mem_we), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_wdata", 32'(mem_wdata), 32'd0);
        exp_q.delete();
        mem_ready = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        check("post_rst_mem_we", 32'(mem_we), 32'd0);
        check("post_rst_status", 32'({busy, done}), 32'd0);
        check("post_rst_count", 32'(count), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
